fwd_ctrl_unit: RTL and testbench

- Sequential forwarding and hazard controller for the 5-stage pipeline.
- Tracks destination and write-enable info for instructions in EX, MEM and WB using internal shadow stage registers.
- Drives the 2-bit select codes consumed by the EX-stage 3-input operand muxes.
- Raises a load-use stall request toward the ID stage.

---
 rtl/fwd_ctrl_unit_pkg.sv | 39 +++
 rtl/fwd_ctrl_unit_if.sv | 57 +++++
 rtl/fwd_ctrl_unit_sel_logic.sv | 32 +++
 rtl/fwd_ctrl_unit.sv | 104 ++++++++++
 tb/tb_fwd_ctrl_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding/hazard controller and the EX-stage
// operand muxes that consume its select codes.
//   FWD_SEL_*      : operand mux select encoding (2'b11 is never driven)
//   DEF_REG_ADDR_W : default register-index width
//   stage_rec_t    : MEM/WB shadow record {valid, rd, reg_write}
//   ex_rec_t       : EX shadow record, adds rs1/rs2/mem_read
//   rec_hits()     : true when a record produces register rs (x0 excluded)
// ---------------------------------------------------------------------------
package fwd_pkg;

    localparam logic [1:0] FWD_SEL_RF  = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    localparam int unsigned DEF_REG_ADDR_W = 5;

    typedef struct packed {
        logic                      valid;
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic                      reg_write;
    } stage_rec_t;

    typedef struct packed {
        logic                      valid;
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic                      reg_write;
        logic [DEF_REG_ADDR_W-1:0] rs1;
        logic [DEF_REG_ADDR_W-1:0] rs2;
        logic                      mem_read;
    } ex_rec_t;

    function automatic logic rec_hits(input stage_rec_t rec,
                                      input logic [DEF_REG_ADDR_W-1:0] rs);
        return rec.valid && rec.reg_write && (rec.rd != '0) && (rec.rd == rs);
    endfunction

endpackage

// File: rtl/fwd_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// fwd_ctrl_unit_if
// Bundle between the ID/EX pipeline control and the forwarding controller.
//   master : drives pipe_en, flush and the ID-stage instruction fields,
//            receives fwd_sel_a/b, stall (and stall_cnt)
//   slave  : the forwarding controller side
// Optional: FWD_STALL_CNT_EN adds the CNT_W-bit stall_cnt signal.
// ---------------------------------------------------------------------------
interface fwd_ctrl_unit_if
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned CNT_W      = 32
);
    logic                  pipe_en;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [1:0]            fwd_sel_a;
    logic [1:0]            fwd_sel_b;
    logic                  stall;

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output pipe_en, flush, id_valid, id_rs1, id_rs2, id_rd,
               id_reg_write, id_mem_read,
        input  fwd_sel_a, fwd_sel_b, stall, stall_cnt
    );

    modport slave (
        input  pipe_en, flush, id_valid, id_rs1, id_rs2, id_rd,
               id_reg_write, id_mem_read,
        output fwd_sel_a, fwd_sel_b, stall, stall_cnt
    );
`else
    localparam int unsigned unused_cnt_w = CNT_W;

    modport master (
        output pipe_en, flush, id_valid, id_rs1, id_rs2, id_rd,
               id_reg_write, id_mem_read,
        input  fwd_sel_a, fwd_sel_b, stall
    );

    modport slave (
        input  pipe_en, flush, id_valid, id_rs1, id_rs2, id_rd,
               id_reg_write, id_mem_read,
        output fwd_sel_a, fwd_sel_b, stall
    );
`endif

endinterface

// File: rtl/fwd_ctrl_unit_sel_logic.sv
// ---------------------------------------------------------------------------
// fwd_sel_logic
// Combinational select for one EX operand mux.
//   i_ex_valid : EX holds a real instruction
//   i_ex_rs    : EX source register for this operand
//   i_mem      : MEM shadow record
//   i_wb       : WB shadow record
//   o_sel      : FWD_SEL_MEM / FWD_SEL_WB / FWD_SEL_RF
// MEM is checked first: it holds the younger producer of the same register.
// ---------------------------------------------------------------------------
module fwd_sel_logic
    import fwd_pkg::*;
(
    input  logic                      i_ex_valid,
    input  logic [DEF_REG_ADDR_W-1:0] i_ex_rs,
    input  stage_rec_t                i_mem,
    input  stage_rec_t                i_wb,
    output logic [1:0]                o_sel
);

    always_comb begin
        o_sel = FWD_SEL_RF;
        if (i_ex_valid) begin
            if (rec_hits(i_mem, i_ex_rs)) begin
                o_sel = FWD_SEL_MEM;
            end else if (rec_hits(i_wb, i_ex_rs)) begin
                o_sel = FWD_SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// ---------------------------------------------------------------------------
// fwd_ctrl_unit
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps shadow records of the instructions in EX, MEM and WB and derives the
// EX operand mux selects and the ID-stage stall request from them.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (overrides pipe_en)
//   bus : fwd_ctrl_unit_if.slave
//         in  pipe_en, flush, id_valid, id_rs1, id_rs2, id_rd,
//             id_reg_write, id_mem_read
//         out fwd_sel_a, fwd_sel_b, stall, stall_cnt (FWD_STALL_CNT_EN only)
// Optional: define FWD_STALL_CNT_EN for the wrapping stall-cycle counter.
// ---------------------------------------------------------------------------
module fwd_ctrl_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned CNT_W      = 32
)
(
    input  logic            clk,
    input  logic            rst,
    fwd_ctrl_unit_if.slave  bus
);

    ex_rec_t    r_ex;
    stage_rec_t r_mem;
    stage_rec_t r_wb;

    logic                  w_stall;
    logic [1:0]            w_sel_a;
    logic [1:0]            w_sel_b;
    logic [REG_ADDR_W-1:0] w_id_rs1;
    logic [REG_ADDR_W-1:0] w_id_rs2;
    logic [REG_ADDR_W-1:0] w_id_rd;

    assign w_id_rs1 = bus.id_rs1;
    assign w_id_rs2 = bus.id_rs2;
    assign w_id_rd  = bus.id_rd;

    // Load in EX whose destination is read by the real instruction in ID.
    assign w_stall = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                     bus.id_valid &&
                     ((r_ex.rd == w_id_rs1) || (r_ex.rd == w_id_rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (bus.pipe_en) begin
            r_wb  <= r_mem;
            r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, reg_write: r_ex.reg_write};
            // Stall and flush both just insert one bubble into EX.
            if (w_stall || bus.flush) begin
                r_ex <= '0;
            end else begin
                r_ex <= '{valid:     bus.id_valid,
                          rd:        w_id_rd,
                          reg_write: bus.id_reg_write,
                          rs1:       w_id_rs1,
                          rs2:       w_id_rs2,
                          mem_read:  bus.id_mem_read};
            end
        end
    end

    fwd_sel_logic u_sel_a (
        .i_ex_valid (r_ex.valid),
        .i_ex_rs    (r_ex.rs1),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (w_sel_a)
    );

    fwd_sel_logic u_sel_b (
        .i_ex_valid (r_ex.valid),
        .i_ex_rs    (r_ex.rs2),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (w_sel_b)
    );

    assign bus.fwd_sel_a = w_sel_a;
    assign bus.fwd_sel_b = w_sel_b;
    assign bus.stall     = w_stall;

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (bus.pipe_en && w_stall) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_ctrl_unit
// Scoreboard bench for fwd_ctrl_unit. The reference keeps the history of
// instructions that entered EX; the newest entry is in EX, the one before it
// in MEM, the one before that in WB. Expected outputs per cycle are queued
// by the stimulus process and checked by an independent monitor.
// ---------------------------------------------------------------------------
module tb_fwd_ctrl_unit;
    import fwd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) bif ();

    fwd_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        bit valid;
        int rd;
        int rs1;
        int rs2;
        bit rw;
        bit mr;
    } ins_t;

    typedef struct {
        int          sa;
        int          sb;
        bit          st;
        int unsigned cnt;
    } exp_t;

    ins_t        hist[$];
    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_cnt  = 0;
    bit          last_stall = 1'b0;
    bit          done = 1'b0;

    function automatic ins_t bubble();
        ins_t b;
        b.valid = 1'b0; b.rd = 0; b.rs1 = 0; b.rs2 = 0; b.rw = 1'b0; b.mr = 1'b0;
        return b;
    endfunction

    function automatic void reset_model();
        hist.delete();
        repeat (3) hist.push_back(bubble());
        m_cnt = 0;
    endfunction

    // Youngest older producer of rs wins; x0 is never a producer.
    function automatic int pred_sel(input int rs);
        ins_t e;
        ins_t p;
        e = hist[hist.size()-1];
        if (!e.valid) return 0;
        for (int age = 1; age <= 2; age++) begin
            p = hist[hist.size()-1-age];
            if (p.valid && p.rw && p.rd != 0 && p.rd == rs)
                return (age == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit pred_stall(input bit v, input int rs1, input int rs2);
        ins_t e;
        e = hist[hist.size()-1];
        return e.valid && e.mr && e.rd != 0 && v && (e.rd == rs1 || e.rd == rs2);
    endfunction

    task automatic cyc(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr, input bit pe, input bit fl,
                       input bit r);
        exp_t x;
        ins_t n;
        bif.id_valid     = v;
        bif.id_rs1       = 5'(rs1);
        bif.id_rs2       = 5'(rs2);
        bif.id_rd        = 5'(rd);
        bif.id_reg_write = rw;
        bif.id_mem_read  = mr;
        bif.pipe_en      = pe;
        bif.flush        = fl;
        rst              = r;
        x.sa  = pred_sel(hist[hist.size()-1].rs1);
        x.sb  = pred_sel(hist[hist.size()-1].rs2);
        x.st  = pred_stall(v, rs1, rs2);
        x.cnt = m_cnt;
        sb_q.push_back(x);
        @(posedge clk);
        if (r) begin
            reset_model();
        end else if (pe) begin
            if (x.st) m_cnt++;
            if (x.st || fl) begin
                n = bubble();
            end else begin
                n.valid = v; n.rd = rd; n.rs1 = rs1; n.rs2 = rs2; n.rw = rw; n.mr = mr;
            end
            hist.push_back(n);
            void'(hist.pop_front());
        end
        last_stall = x.st;
        #1;
    endtask

    // Presents an instruction in ID and keeps it there while a stall holds it.
    task automatic issue(input int rs1, input int rs2, input int rd,
                         input bit rw, input bit mr);
        int tries;
        tries = 0;
        do begin
            cyc(1'b1, rs1, rs2, rd, rw, mr, 1'b1, 1'b0, 1'b0);
            tries++;
        end while (last_stall && tries < 4);
        if (last_stall) begin
            checks++;
            errors++;
            $display("FAIL issue_hold: stall still %0d after %0d cycles, required 0", last_stall, tries);
        end
    endtask

    task automatic nop(input int k);
        repeat (k) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bif.fwd_sel_a !== 2'(e.sa)) begin
                errors++;
                $display("FAIL fwd_sel_a @%0t: got %b want %b", $time, bif.fwd_sel_a, 2'(e.sa));
            end
            checks++;
            if (bif.fwd_sel_b !== 2'(e.sb)) begin
                errors++;
                $display("FAIL fwd_sel_b @%0t: got %b want %b", $time, bif.fwd_sel_b, 2'(e.sb));
            end
            checks++;
            if (bif.stall !== e.st) begin
                errors++;
                $display("FAIL stall @%0t: got %b want %b", $time, bif.stall, e.st);
            end
`ifdef FWD_STALL_CNT_EN
            checks++;
            if (bif.stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, bif.stall_cnt, e.cnt);
            end
`endif
        end
    end

    initial begin
        rst = 1'b1;
        bif.pipe_en = 1'b1; bif.flush = 1'b0; bif.id_valid = 1'b0;
        bif.id_rs1 = '0; bif.id_rs2 = '0; bif.id_rd = '0;
        bif.id_reg_write = 1'b0; bif.id_mem_read = 1'b0;
        @(posedge clk);
        reset_model();
        #1;

        // Reset held with random inputs
        repeat (2) cyc(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), 1'b1, 1'($urandom), 1'($urandom),
                       1'($urandom), 1'b1);
        nop(1);

        // EX/MEM forward: add x5 ; sub x7, x5, x6
        issue(1, 2, 5, 1'b1, 1'b0);
        issue(5, 6, 7, 1'b1, 1'b0);
        nop(3);

        // Double hazard: MEM beats WB
        issue(1, 2, 5, 1'b1, 1'b0);
        issue(3, 4, 5, 1'b1, 1'b0);
        issue(5, 5, 8, 1'b1, 1'b0);
        nop(3);
        // Nop between producer and consumer: WB forward
        issue(1, 2, 5, 1'b1, 1'b0);
        nop(1);
        issue(5, 5, 8, 1'b1, 1'b0);
        nop(3);

        // Load-use: lw x3 ; add x4, x3, x1
        issue(2, 0, 3, 1'b1, 1'b1);
        issue(3, 1, 4, 1'b1, 1'b0);
        nop(3);

        // x0 is neither forwarded nor stalls
        issue(1, 2, 0, 1'b1, 1'b0);
        issue(0, 0, 9, 1'b1, 1'b0);
        nop(2);
        issue(1, 0, 0, 1'b1, 1'b1);
        issue(0, 0, 9, 1'b1, 1'b0);
        nop(3);

        // Freeze for 3 cycles mid-hazard
        issue(1, 2, 6, 1'b1, 1'b0);
        issue(2, 0, 3, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 3, 6, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(3, 6, 4, 1'b1, 1'b0);
        nop(3);

        // Flush and stall on the same edge
        issue(1, 2, 5, 1'b1, 1'b0);
        issue(2, 0, 3, 1'b1, 1'b1);
        cyc(1'b1, 3, 5, 4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        nop(3);

        // Reset asserted while stalling
        issue(2, 0, 3, 1'b1, 1'b1);
        cyc(1'b1, 3, 1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(3, 1, 4, 1'b1, 1'b0);
        nop(2);

        // Random traffic on a small register set to provoke hits
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 49) == 0));
        end

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        done = 1'b1;
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: bench did not complete, checks %0d", checks);
            $fatal(1, "timeout");
        end
    end

endmodule
